// File: rtl/uart_pkg.sv
// Shared UART definitions: frame constants, FSM state encodings and the baud
// divider helper used by both the transmitter and the receiver.
package uart_pkg;

    localparam int DATA_BITS = 8;
    localparam int STOP_BITS = 1;

    // Byte serializer states (START/DATA/STOP of the line protocol).
    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_e;

    // Word sequencing states; DUMP_SEND covers the START/DATA/STOP span of a byte.
    typedef enum logic [1:0] {
        DUMP_IDLE,
        DUMP_FETCH,
        DUMP_LATCH,
        DUMP_SEND
    } dump_state_e;

    function automatic int clks_per_bit(input int freq_hz, input int baud);
        return freq_hz / baud;
    endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serializer with a registered line output. A new byte may be loaded
// in the last cycle of the stop bit so back-to-back frames have no gap.
module uart_tx_byte
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_load,
    input  logic [7:0] i_byte,
    output logic       o_ready,
    output logic       o_frame_end,
    output logic       o_tx
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IDX_W = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_BITS - 1);
    localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);

    tx_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [IDX_W-1:0] idx_inc;
    logic [7:0]       byte_q, byte_d;
    logic             tx_q, tx_d;
    logic             bit_end;

    assign bit_end     = (cnt_q == CNT_LAST);
    assign idx_inc     = idx_q + 1'b1;
    assign o_frame_end = (state_q == TX_STOP) && bit_end && (idx_q == STOP_LAST);
    assign o_ready     = (state_q == TX_IDLE) || o_frame_end;
    assign o_tx        = tx_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = bit_end ? '0 : cnt_q + 1'b1;
        idx_d   = idx_q;
        byte_d  = byte_q;
        tx_d    = tx_q;
        case (state_q)
            TX_IDLE: begin
                cnt_d = '0;
                tx_d  = 1'b1;
            end
            TX_START: begin
                if (bit_end) begin
                    state_d = TX_DATA;
                    idx_d   = '0;
                    tx_d    = byte_q[0];
                end
            end
            TX_DATA: begin
                if (bit_end) begin
                    if (idx_q == DATA_LAST) begin
                        state_d = TX_STOP;
                        idx_d   = '0;
                        tx_d    = 1'b1;
                    end else begin
                        idx_d = idx_inc;
                        tx_d  = byte_q[idx_inc];
                    end
                end
            end
            TX_STOP: begin
                if (bit_end) begin
                    if (idx_q != STOP_LAST) begin
                        idx_d = idx_inc;
                    end else begin
                        state_d = TX_IDLE;
                        tx_d    = 1'b1;
                    end
                end
            end
            default: begin
                state_d = TX_IDLE;
                tx_d    = 1'b1;
            end
        endcase
        // A load overrides the stop-bit exit so the next start bit follows directly.
        if (i_load && o_ready) begin
            state_d = TX_START;
            cnt_d   = '0;
            byte_d  = i_byte;
            tx_d    = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= TX_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            byte_q  <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            byte_q  <= byte_d;
            tx_q    <= tx_d;
        end
    end

endmodule

// File: rtl/uart_dump_tx.sv
// Dumps instruction words 0..max from the BRAM read port over UART, high byte
// first. The high byte goes straight from the read data into the serializer.
module uart_dump_tx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 50_000_000,
    parameter int BAUD        = 115200,
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 16
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic [ADDR_W-1:0] i_max_addr,
    output logic [ADDR_W-1:0] o_addr_read,
    input  logic [DATA_W-1:0] i_data_read,
    output logic              o_tx,
    output logic              o_busy,
    output logic              o_done
);

    localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ_HZ, BAUD);

    dump_state_e       state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] max_q, max_d;
    logic [7:0]        low_q, low_d;
    logic              byte_sel_q, byte_sel_d;
    logic              done_q, done_d;

    logic              tx_load;
    logic [7:0]        tx_byte;
    logic              tx_ready;
    logic              tx_frame_end;

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        max_d      = max_q;
        low_d      = low_q;
        byte_sel_d = byte_sel_q;
        done_d     = 1'b0;
        tx_load    = 1'b0;
        tx_byte    = low_q;
        case (state_q)
            DUMP_IDLE: begin
                if (i_start) begin
                    addr_d  = '0;
                    max_d   = i_max_addr;
                    state_d = DUMP_FETCH;
                end
            end
            DUMP_FETCH: begin
                state_d = DUMP_LATCH;
            end
            DUMP_LATCH: begin
                // Read data stays valid while the address is held, so waiting is safe.
                if (tx_ready) begin
                    tx_load    = 1'b1;
                    tx_byte    = i_data_read[DATA_W-1 -: 8];
                    low_d      = i_data_read[7:0];
                    byte_sel_d = 1'b1;
                    state_d    = DUMP_SEND;
                end
            end
            DUMP_SEND: begin
                if (tx_frame_end) begin
                    if (byte_sel_q) begin
                        tx_load    = 1'b1;
                        tx_byte    = low_q;
                        byte_sel_d = 1'b0;
                    end else if (addr_q != max_q) begin
                        addr_d  = addr_q + 1'b1;
                        state_d = DUMP_FETCH;
                    end else begin
                        done_d  = 1'b1;
                        state_d = DUMP_IDLE;
                    end
                end
            end
            default: begin
                state_d = DUMP_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= DUMP_IDLE;
            addr_q     <= '0;
            max_q      <= '0;
            low_q      <= '0;
            byte_sel_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            max_q      <= max_d;
            low_q      <= low_d;
            byte_sel_q <= byte_sel_d;
            done_q     <= done_d;
        end
    end

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_tx_byte (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_load     (tx_load),
        .i_byte     (tx_byte),
        .o_ready    (tx_ready),
        .o_frame_end(tx_frame_end),
        .o_tx       (o_tx)
    );

    assign o_addr_read = addr_q;
    assign o_busy      = (state_q != DUMP_IDLE);
    assign o_done      = done_q;

endmodule

// File: tb/tb_uart_dump_tx.sv
// Directed and randomized dumps of a modelled BRAM; the line is recorded per
// cycle and compared against an ideal 8N1 waveform built from memory contents.
module tb_uart_dump_tx;

    localparam int CLK_FREQ_HZ = 400;
    localparam int BAUD        = 100;
    localparam int C           = CLK_FREQ_HZ / BAUD;
    localparam int FRAME_CYC   = 10 * C;
    localparam int WORD_CYC    = 20 * C + 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  max_addr = '0;
    logic [7:0]  addr_read;
    logic [15:0] data_read = '0;
    logic        tx, busy, done;

    logic [15:0] mem [0:255];

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    always @(posedge clk) data_read <= mem[addr_read];

    uart_dump_tx #(
        .CLK_FREQ_HZ(CLK_FREQ_HZ),
        .BAUD       (BAUD),
        .ADDR_W     (8),
        .DATA_W     (16)
    ) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_start    (start),
        .i_max_addr (max_addr),
        .o_addr_read(addr_read),
        .i_data_read(data_read),
        .o_tx       (tx),
        .o_busy     (busy),
        .o_done     (done)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Ideal line level at slot pos (0 = start, 1..8 = data LSB first, 9 = stop).
    function automatic bit line_bit(input logic [7:0] b, input int pos);
        if (pos == 0) return 1'b0;
        if (pos == 9) return 1'b1;
        return b[pos-1];
    endfunction

    // Start a dump of words 0..mx; optionally re-pulse start with max 0 at cycle repulse_k.
    task automatic run_dump(input int mx, input int repulse_k, input string tag);
        int         total;
        bit         line_q[$];
        int         done_cnt, done_at, busy_low, addr_back, mism, base;
        logic [7:0] prev_addr, exp_b, dec;
        total     = (mx + 1) * WORD_CYC;
        done_cnt  = 0;
        done_at   = -1;
        busy_low  = -1;
        addr_back = 0;
        @(negedge clk);
        start    = 1'b1;
        max_addr = mx[7:0];
        @(negedge clk);
        start     = 1'b0;
        max_addr  = 8'($urandom);
        prev_addr = addr_read;
        for (int k = 0; k <= total + 3; k++) begin
            if (k > 0) @(negedge clk);
            line_q.push_back(tx);
            if (done === 1'b1) begin
                done_cnt++;
                if (done_at < 0) done_at = k;
            end
            if (busy !== 1'b1 && busy_low < 0) busy_low = k;
            if (addr_read < prev_addr) addr_back++;
            prev_addr = addr_read;
            if (k == repulse_k) begin
                start    = 1'b1;
                max_addr = 8'd0;
            end else begin
                start = 1'b0;
            end
        end
        chk({tag, " done_count"}, done_cnt, 1);
        chk({tag, " done_cycle"}, done_at, total);
        chk({tag, " busy_fall"}, busy_low, total);
        chk({tag, " addr_no_wrap"}, addr_back, 0);
        chk({tag, " final_addr"}, {24'd0, addr_read}, mx);
        for (int w = 0; w <= mx; w++) begin
            base = w * WORD_CYC;
            chk($sformatf("%s w%0d gap", tag, w), {line_q[base], line_q[base+1]}, 2'b11);
            for (int b = 0; b < 2; b++) begin
                exp_b = (b == 0) ? mem[w][15:8] : mem[w][7:0];
                base  = w * WORD_CYC + 2 + b * FRAME_CYC;
                mism  = 0;
                for (int p = 0; p < FRAME_CYC; p++)
                    if (line_q[base+p] != line_bit(exp_b, p / C)) mism++;
                for (int i = 0; i < 8; i++)
                    dec[i] = line_q[base + (i + 1) * C + C / 2];
                chk($sformatf("%s w%0d b%0d frame", tag, w, b),
                    {mism[15:0], 8'd0, dec}, {16'd0, 8'd0, exp_b});
            end
        end
        chk({tag, " trailing_idle"},
            {line_q[total], line_q[total+1], line_q[total+2], line_q[total+3]}, 4'hF);
    endtask

    initial begin
        int bad_tx, bad_busy, bad_addr, bad_done, mx, rk;

        for (int a = 0; a < 256; a++) mem[a] = 16'($urandom);

        // Reset values while held, then 100 idle cycles with no start.
        repeat (3) @(negedge clk);
        chk("rst_tx", tx, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_addr", addr_read, 0);
        rst_n = 1'b1;
        bad_tx = 0; bad_busy = 0; bad_addr = 0; bad_done = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (tx !== 1'b1) bad_tx++;
            if (busy !== 1'b0) bad_busy++;
            if (addr_read !== 8'd0) bad_addr++;
            if (done !== 1'b0) bad_done++;
        end
        chk("idle_tx", bad_tx, 0);
        chk("idle_busy", bad_busy, 0);
        chk("idle_addr", bad_addr, 0);
        chk("idle_done", bad_done, 0);

        mem[0] = 16'hA55A;
        run_dump(0, -1, "single");

        mem[0] = 16'h0102; mem[1] = 16'h0304; mem[2] = 16'h0506;
        run_dump(2, -1, "three");
        run_dump(2, 100, "repulse");

        for (int t = 0; t < 4; t++) begin
            for (int a = 0; a < 8; a++) mem[a] = 16'($urandom);
            mx = int'($urandom_range(0, 7));
            rk = int'($urandom_range(0, (mx + 1) * WORD_CYC - 1));
            run_dump(mx, rk, $sformatf("rand%0d", t));
        end

        for (int a = 0; a < 256; a++) mem[a] = {a[7:0], ~a[7:0]};
        run_dump(255, -1, "full");

        // Asynchronous reset during data bit 3 of the low byte of word 0.
        mem[0] = 16'h0102; mem[1] = 16'h0304; mem[2] = 16'h0506;
        @(negedge clk);
        start    = 1'b1;
        max_addr = 8'd2;
        @(negedge clk);
        start = 1'b0;
        repeat (59) @(negedge clk);
        chk("midframe_bit3", tx, 0);
        rst_n = 1'b0;
        #1;
        chk("async_rst_tx", tx, 1);
        chk("async_rst_busy", busy, 0);
        chk("async_rst_addr", addr_read, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        bad_tx = 0; bad_busy = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (tx !== 1'b1) bad_tx++;
            if (busy !== 1'b0) bad_busy++;
        end
        chk("post_rst_tx", bad_tx, 0);
        chk("post_rst_busy", bad_busy, 0);
        mem[0] = 16'hC33C; mem[1] = 16'h9669;
        run_dump(1, -1, "restart");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_dump_tx.md
# uart_dump_tx

Reads instruction words back out of the instruction BRAM read port and transmits them over a UART TX line, high byte first, as the mirror of the UART instruction loader. Sits beside the instruction ROM on the CPU clock domain, sharing its read port while the CPU is halted. Used to verify a loaded program from the host side.

## Interface

- CLK_FREQ_HZ, 50_000_000: frequency of i_clk.
- BAUD, 115200: line rate. CLKS_PER_BIT = CLK_FREQ_HZ / BAUD (integer division, must be ≥ 2).
- ADDR_W, 8: BRAM address width.
- DATA_W, 16: word width; fixed at 2 bytes per word.

- i_clk  in  1  single clock; all logic on the rising edge.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_start  in  1  one-cycle request to begin a dump; accepted only when o_busy = 0.
- i_max_addr  in  ADDR_W  last address to send (inclusive); sampled when i_start is accepted.
- o_addr_read  out  ADDR_W  BRAM read address.
- i_data_read  in  DATA_W  BRAM read data; valid 1 cycle after o_addr_read changes.
- o_tx  out  1  UART line, 8N1, idle high.
- o_busy  out  1  high from the cycle after start acceptance through the final stop bit.
- o_done  out  1  one-cycle pulse after the final stop bit.

## Operation

- FSM states: IDLE, FETCH, LATCH, START, DATA, STOP.
- IDLE: o_tx = 1. On i_start: addr ← 0, max ← i_max_addr, → FETCH.
- FETCH: o_addr_read = addr; wait 1 cycle → LATCH.
- LATCH: word ← i_data_read, byte_sel ← 1 (high byte) → START.
- START: o_tx = 0 for CLKS_PER_BIT cycles → DATA, bit_idx ← 0.
- DATA: o_tx = cur_byte[bit_idx], LSB first, CLKS_PER_BIT cycles per bit; after bit 7 → STOP.
- STOP: o_tx = 1 for CLKS_PER_BIT cycles, then:
  - byte_sel = 1: byte_sel ← 0, → START (low byte).
  - byte_sel = 0, addr ≠ max: addr ← addr + 1, → FETCH.
  - byte_sel = 0, addr = max: pulse o_done, → IDLE.
- Compare before increment: max = 2^ADDR_W − 1 sends every word with no address wrap.
- i_start while busy: ignored, no effect on the dump or on the sampled max.
- i_max_addr changes mid-dump: ignored.
- i_data_read sampled only in LATCH.

## Timing

- Reset values: o_tx = 1, o_busy = 0, o_done = 0, o_addr_read = 0, FSM = IDLE. Reset mid-frame drives o_tx high immediately (asynchronous) and abandons the dump.
- Start bit begins 2 cycles after the i_start edge (FETCH, LATCH).
- Byte frame: exactly 10 × CLKS_PER_BIT cycles.
- High→low byte of one word: no gap; stop bit followed directly by the start bit.
- Between words: 2 idle-high cycles (FETCH, LATCH) after the stop bit.
- Total dump of N = max+1 words: N × (20 × CLKS_PER_BIT + 2) cycles from i_start to o_done, inclusive of the pulse cycle.
- o_busy falls in the same cycle o_done rises.
- o_tx is registered; it comes from a flop with no combinational path.

## Structure

- Shared package uart_pkg: FSM state enum; frame constants (DATA_BITS = 8, STOP_BITS = 1); clks_per_bit(freq, baud) function, reused by the receiver.
- Sub-module uart_tx_byte: byte serializer (START/DATA/STOP, baud counter, bit index, load/ready handshake). The word fetch and byte sequencing stay in uart_dump_tx.
- Baud counter width: $clog2(CLKS_PER_BIT).

## Test plan

Simulate with CLK_FREQ_HZ = 400 and BAUD = 100, so CLKS_PER_BIT = 4.

- Reset, no start → o_tx = 1, o_busy = 0, o_addr_read = 0 held for 100 cycles.
- BRAM[0] = 16'hA55A, i_start with max = 0 → line decodes bytes 0xA5 then 0x5A; o_done pulses once at cycle 2 + 80; o_busy drops the same cycle.
- BRAM[0..2] = 16'h0102, 16'h0304, 16'h0506, max = 2 → bytes 01 02 03 04 05 06; 2-cycle idle gaps between words, none within a word; o_done at cycle 246.
- max = 255, BRAM[a] = {a, ~a} → 512 bytes, last pair FF 00; o_addr_read never wraps to 0 after 255; exactly one o_done.
- i_start re-pulsed mid-dump with i_max_addr = 0 while max = 2 → ignored; all 6 bytes are still sent.
- i_rst_n asserted during the DATA bit 3 of byte 1 → o_tx = 1 before the next clock edge; IDLE after release; a new i_start restarts from address 0.
